// File: rtl/connect_bot_pkg.sv
// Shared types and helpers for the sequential connect-four move scanner.
package connect_bot_pkg;

    typedef enum logic [1:0] {
        MC_NONE  = 2'd0,
        MC_WIN   = 2'd1,
        MC_BLOCK = 2'd2,
        MC_BUILD = 2'd3
    } move_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_e;

    // Flat bit index of cell (r,c); row 0 is the bottom row.
    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Column visited at scan step i: centre, centre-1, centre+1, centre-2, ...
    // Out-of-range candidates are skipped, so even widths also enumerate every column.
    function automatic int scan_col(input int i, input int cols);
        int centre;
        int n;
        int cand;
        int res;
        centre = (cols - 1) / 2;
        n      = 0;
        res    = 0;
        for (int j = 0; j < 2 * cols; j++) begin
            if (j == 0)
                cand = centre;
            else if ((j % 2) == 1)
                cand = centre - (j + 1) / 2;
            else
                cand = centre + j / 2;
            if (cand >= 0 && cand < cols) begin
                if (n == i)
                    res = cand;
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/connect_bot_scan_if.sv
// Controller <-> bot bundle: request, board bitmaps and the registered result.
interface connect_bot_scan_if #(
    parameter int ROWS  = 6,
    parameter int COLS  = 7,
    parameter int COL_W = $clog2(COLS)
);
    import connect_bot_pkg::*;

    logic                 start;
    logic [ROWS*COLS-1:0] color_p0;
    logic [ROWS*COLS-1:0] color_p1;
    logic                 busy;
    logic                 done;
    logic [COL_W-1:0]     sel_col;
    logic                 sel_valid;
    move_class_e          move_class;
    logic                 err;

    modport master (
        output start, color_p0, color_p1,
        input  busy, done, sel_col, sel_valid, move_class, err
    );

    modport slave (
        input  start, color_p0, color_p1,
        output busy, done, sel_col, sel_valid, move_class, err
    );
endinterface

// File: rtl/line_len_eval.sv
// Longest line through one cell, with that cell counted as the player's own piece.
module line_len_eval #(
    parameter int ROWS  = 6,
    parameter int COLS  = 7,
    parameter int WIN   = 4,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic [ROWS*COLS-1:0]                          cells,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    row,
    input  logic [COL_W-1:0]                              col,
    output logic [$clog2(WIN+1)-1:0]                      len
);
    localparam int CELLS = ROWS * COLS;
    localparam int LEN_W = $clog2(WIN + 1);

    int   best;
    int   run;
    int   rr;
    int   cc;
    int   dr;
    int   dc;
    logic alive;

    // Walk up to WIN-1 cells each way along the four directions and keep the longest run.
    always_comb begin
        // NOTE: every variable gets a default before the loops so no path leaves one holding state (no latch).
        best  = 1;
        run   = 0;
        rr    = 0;
        cc    = 0;
        dr    = 0;
        dc    = 0;
        alive = 1'b0;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin dr = 0; dc = 1;  end
                1:       begin dr = 1; dc = 0;  end
                2:       begin dr = 1; dc = 1;  end
                default: begin dr = 1; dc = -1; end
            endcase
            run = 1;
            for (int s = 0; s < 2; s++) begin
                alive = 1'b1;
                for (int k = 1; k < WIN; k++) begin
                    // NOTE: blocking assignments here so each step sees the run counted by the previous one.
                    rr = (s == 0) ? int'(row) + k * dr : int'(row) - k * dr;
                    cc = (s == 0) ? int'(col) + k * dc : int'(col) - k * dc;
                    if (alive && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                        if (|(cells & (CELLS'(1) << (rr * COLS + cc))))
                            run = run + 1;
                        else
                            alive = 1'b0;
                    end else begin
                        alive = 1'b0;
                    end
                end
            end
            if (run > best)
                best = run;
        end
        if (best > WIN)
            best = WIN;
        len = LEN_W'(best);
    end
endmodule

// File: rtl/connect_bot_scan.sv
// Sequential connect-four bot: snapshots the board, scans one column per cycle centre-out, reports the best move.
module connect_bot_scan
    import connect_bot_pkg::*;
#(
    parameter int ROWS  = 6,
    parameter int COLS  = 7,
    parameter int WIN   = 4,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    connect_bot_scan_if.slave bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LEN_W = $clog2(WIN + 1);
    localparam int KEY_W = 2 + LEN_W;

    state_e           state;
    logic [CELLS-1:0] snap_p0;
    logic [CELLS-1:0] snap_p1;
    logic             overlap;
    logic [COL_W-1:0] scan_i;
    logic [COL_W-1:0] best_col;
    logic [KEY_W-1:0] best_key;
    move_class_e      best_class;

    logic [COL_W-1:0] cur_col;
    logic [CELLS-1:0] occ;
    logic [ROW_W-1:0] land_row;
    logic             col_full;
    logic [LEN_W-1:0] len_p0;
    logic [LEN_W-1:0] len_p1;
    move_class_e      cand_class;
    logic [KEY_W-1:0] cand_key;

    assign cur_col = COL_W'(scan_col(int'(scan_i), COLS));
    assign occ     = snap_p0 | snap_p1;

    // Landing cell: lowest empty row of the column under evaluation.
    always_comb begin
        land_row = '0;
        col_full = 1'b1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!(|(occ & (CELLS'(1) << idx(r, int'(cur_col), COLS))))) begin
                land_row = ROW_W'(r);
                col_full = 1'b0;
            end
        end
    end

    line_len_eval #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN), .COL_W(COL_W)) u_len_p0 (
        .cells (snap_p0),
        .row   (land_row),
        .col   (cur_col),
        .len   (len_p0)
    );

    line_len_eval #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN), .COL_W(COL_W)) u_len_p1 (
        .cells (snap_p1),
        .row   (land_row),
        .col   (cur_col),
        .len   (len_p1)
    );

    // Rank key: tier in the top bits (WIN > BLOCK > BUILD), build score below; larger key is better.
    always_comb begin
        cand_class = MC_BUILD;
        cand_key   = {2'd1, len_p0};
        if (len_p0 >= LEN_W'(WIN)) begin
            cand_class = MC_WIN;
            cand_key   = {2'd3, LEN_W'(0)};
        end else if (len_p1 >= LEN_W'(WIN)) begin
            cand_class = MC_BLOCK;
            cand_key   = {2'd2, LEN_W'(0)};
        end
    end

    // Control FSM with the snapshot, running best and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            snap_p0        <= '0;
            snap_p1        <= '0;
            overlap        <= 1'b0;
            scan_i         <= '0;
            best_col       <= '0;
            best_key       <= '0;
            best_class     <= MC_NONE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.sel_col    <= '0;
            bus.sel_valid  <= 1'b0;
            bus.move_class <= MC_NONE;
            bus.err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= S_LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    snap_p0    <= bus.color_p0;
                    snap_p1    <= bus.color_p1;
                    overlap    <= |(bus.color_p0 & bus.color_p1);
                    best_col   <= '0;
                    best_key   <= '0;
                    best_class <= MC_NONE;
                    scan_i     <= '0;
                    state      <= S_SCAN;
                end
                S_SCAN: begin
                    // Strictly-better only, so ties stay with the column nearer the centre.
                    if (!col_full && cand_key > best_key) begin
                        best_key   <= cand_key;
                        best_col   <= cur_col;
                        best_class <= cand_class;
                    end
                    if (scan_i == COL_W'(COLS - 1)) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                    end else begin
                        scan_i <= scan_i + COL_W'(1);
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                    if (overlap) begin
                        bus.err        <= 1'b1;
                        bus.sel_valid  <= 1'b0;
                        bus.sel_col    <= '0;
                        bus.move_class <= MC_NONE;
                    end else begin
                        bus.err        <= 1'b0;
                        bus.sel_valid  <= (best_key != '0);
                        bus.sel_col    <= best_col;
                        bus.move_class <= best_class;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
